exotiny_mem_arb: RTL and testbench
==================================

Name: exotiny_mem_arb

Overview:
- Two-requester Wishbone classic arbiter inside the ExoTiny SoC.
- Shares the single external-memory (QSPI) port between the FazyRV instruction-fetch bus (imem) and the data bus (dmem).
- Sits between the CPU bus interfaces and the memory controller.
- Uses registered round-robin grant with transaction locking until ack.

Parameters:
- ADR_W, 24, address width of all Wishbone ports.
- TIMEOUT_CYC, 255, max cycles from grant to ack; used only when the optional feature is enabled; legal range 1..65535.

Ports:
- clk_i  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- wb_imem_cyc_i  in  1  imem cycle
- wb_imem_stb_i  in  1  imem strobe
- wb_imem_adr_i  in  ADR_W  imem address
- wb_imem_ack_o  out  1  imem ack
- wb_imem_err_o  out  1  imem error (timeout)
- wb_imem_rdat_o  out  32  imem read data
- wb_dmem_cyc_i  in  1  dmem cycle
- wb_dmem_stb_i  in  1  dmem strobe
- wb_dmem_we_i  in  1  dmem write enable
- wb_dmem_be_i  in  4  dmem byte enables
- wb_dmem_adr_i  in  ADR_W  dmem address
- wb_dmem_wdat_i  in  32  dmem write data
- wb_dmem_ack_o  out  1  dmem ack
- wb_dmem_err_o  out  1  dmem error (timeout)
- wb_dmem_rdat_o  out  32  dmem read data
- wb_mem_cyc_o  out  1  shared cycle
- wb_mem_stb_o  out  1  shared strobe
- wb_mem_we_o  out  1  shared write enable
- wb_mem_be_o  out  4  shared byte enables
- wb_mem_adr_o  out  ADR_W  shared address
- wb_mem_wdat_o  out  32  shared write data
- wb_mem_ack_i  in  1  shared ack
- wb_mem_rdat_i  in  32  shared read data
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low on rst_in; a single clock domain.
- State machine states are IDLE, GNT_I and GNT_D. Reset state is IDLE with last_gnt = DMEM, so imem wins the first tie.
- A request is cyc & stb.
- In IDLE:
  - If only one requester requests, go to its GNT state next cycle.
  - If both request, grant the one not equal to last_gnt.
  - Store last_gnt on grant.
- Arbitration latency is exactly 1 cycle from request to wb_mem_cyc_o/stb_o.
- In GNT_x:
  - wb_mem_* outputs are driven combinationally from the granted requester's inputs.
  - On imem grant: we_o = 0, be_o = 4'hF, wdat_o = 0.
  - wb_mem_ack_i routes combinationally to the granted ack_o. Non-granted ack_o = 0.
  - rdat_o of both requesters = wb_mem_rdat_i, unregistered.
- Exit to IDLE:
  - On the wb_mem_ack_i cycle, go to IDLE. A new grant needs at least 1 IDLE cycle; no back-to-back grants.
  - If the granted requester drops cyc before ack, go to IDLE immediately. wb_mem_cyc_o follows the input low the same cycle. A late ack in IDLE is ignored.
- In IDLE, all wb_mem_* outputs = 0.
- Reset values: all outputs 0, timeout_o = 0.
- Reset asserted mid-transaction aborts it: outputs drop asynchronously, no ack is forwarded.
- Simultaneous ack and requester cyc drop: the ack is forwarded and the state goes to IDLE.

Optional Feature:
- Macro EXOTINY_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entering GNT_x and increments each GNT cycle without ack.
  - When count == TIMEOUT_CYC and there is no ack, pulse the granted err_o for 1 cycle and drop wb_mem_cyc_o/stb_o that same cycle.
  - Go to IDLE and set timeout_o, which stays set until reset.
- Undefined:
  - No counter.
  - err_o outputs and timeout_o are tied to 0.
  - A grant waits for ack indefinitely.

Decomposition:
- exotiny_pkg holds:
  - typedef enum arb_state_t {IDLE, GNT_I, GNT_D}
  - typedef enum logic gnt_src_t {SRC_IMEM, SRC_DMEM}
  - localparam WB_DAT_W = 32 and WB_SEL_W = 4
- No sub-module; the timeout counter is inline and guarded by the macro.

Test Plan:
- imem-only read, adr 0x000100: mem cyc rises 1 cycle after request; memory acks after 3 cycles with rdat 0xDEADBEEF -> imem_ack_o = 1 with rdat 0xDEADBEEF; dmem_ack_o = 0 throughout.
- Both request from reset: imem is granted first. Both hold requests through 3 transactions -> grant order I, D, I, with 1 IDLE cycle between each.
- dmem write, be = 4'b0011, wdat 0x0000CAFE, adr 0x000200 -> wb_mem_we_o = 1 and be/wdat/adr passed through unchanged; imem request held meanwhile is granted only after the dmem ack.
- dmem drops cyc 2 cycles into a grant -> mem cyc falls the same cycle; a late ack 1 cycle later produces no ack on either side; FSM is in IDLE.
- rst_in asserted during GNT_I -> all outputs are 0 asynchronously; after release, the first tie goes to imem.
- EXOTINY_ARB_TIMEOUT_EN with TIMEOUT_CYC = 4, memory never acks -> dmem_err_o pulses 1 cycle, 4 cycles after grant; timeout_o = 1 and stays set; the next imem request is still served.

Source files
------------

// File: rtl/exotiny_pkg.sv
// exotiny_mem_arb shared types and bus widths.
// Imported by the imem/dmem to QSPI memory arbiter.
package exotiny_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef enum logic {
    SRC_IMEM,
    SRC_DMEM
  } gnt_src_t;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

endpackage

// File: rtl/exotiny_mem_arb.sv
// Round-robin Wishbone classic arbiter: imem + dmem onto one memory port.
// Optional grant watchdog enabled by macro EXOTINY_ARB_TIMEOUT_EN.
module exotiny_mem_arb
  import exotiny_pkg::*;
#(
  parameter int ADR_W       = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_in,
  input  logic                wb_imem_cyc_i,
  input  logic                wb_imem_stb_i,
  input  logic [ADR_W-1:0]    wb_imem_adr_i,
  output logic                wb_imem_ack_o,
  output logic                wb_imem_err_o,
  output logic [WB_DAT_W-1:0] wb_imem_rdat_o,
  input  logic                wb_dmem_cyc_i,
  input  logic                wb_dmem_stb_i,
  input  logic                wb_dmem_we_i,
  input  logic [WB_SEL_W-1:0] wb_dmem_be_i,
  input  logic [ADR_W-1:0]    wb_dmem_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dmem_wdat_i,
  output logic                wb_dmem_ack_o,
  output logic                wb_dmem_err_o,
  output logic [WB_DAT_W-1:0] wb_dmem_rdat_o,
  output logic                wb_mem_cyc_o,
  output logic                wb_mem_stb_o,
  output logic                wb_mem_we_o,
  output logic [WB_SEL_W-1:0] wb_mem_be_o,
  output logic [ADR_W-1:0]    wb_mem_adr_o,
  output logic [WB_DAT_W-1:0] wb_mem_wdat_o,
  input  logic                wb_mem_ack_i,
  input  logic [WB_DAT_W-1:0] wb_mem_rdat_i,
  output logic                timeout_o
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYC out of range");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  gnt_src_t   last_gnt;
  gnt_src_t   last_nxt;
  logic       req_i;
  logic       req_d;
  logic       to_hit;

  assign req_i = wb_imem_cyc_i & wb_imem_stb_i;
  assign req_d = wb_dmem_cyc_i & wb_dmem_stb_i;

`ifdef EXOTINY_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             to_q;

  assign to_hit = (state != IDLE) && !wb_mem_ack_i &&
                  (cnt == CNT_W'(TIMEOUT_CYC));
  assign timeout_o = to_q;

  // Grant-age counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
      end else if (!wb_mem_ack_i) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (to_hit) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign wb_imem_rdat_o = wb_mem_rdat_i;
  assign wb_dmem_rdat_o = wb_mem_rdat_i;

  // State and round-robin history registers.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      last_gnt <= SRC_DMEM;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_nxt;
    end
  end

  // Next-state arbitration and granted-port muxing.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last_gnt;
    wb_mem_cyc_o  = 1'b0;
    wb_mem_stb_o  = 1'b0;
    wb_mem_we_o   = 1'b0;
    wb_mem_be_o   = '0;
    wb_mem_adr_o  = '0;
    wb_mem_wdat_o = '0;
    wb_imem_ack_o = 1'b0;
    wb_imem_err_o = 1'b0;
    wb_dmem_ack_o = 1'b0;
    wb_dmem_err_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i && (!req_d || last_gnt == SRC_DMEM)) begin
          state_nxt = GNT_I;
          last_nxt  = SRC_IMEM;
        end else if (req_d) begin
          state_nxt = GNT_D;
          last_nxt  = SRC_DMEM;
        end
      end
      GNT_I: begin
        wb_mem_cyc_o  = wb_imem_cyc_i & ~to_hit;
        wb_mem_stb_o  = wb_imem_stb_i & ~to_hit;
        wb_mem_be_o   = 4'hF;
        wb_mem_adr_o  = wb_imem_adr_i;
        wb_imem_ack_o = wb_mem_ack_i;
        wb_imem_err_o = to_hit;
        if (wb_mem_ack_i || !wb_imem_cyc_i || to_hit) begin
          state_nxt = IDLE;
        end
      end
      GNT_D: begin
        wb_mem_cyc_o  = wb_dmem_cyc_i & ~to_hit;
        wb_mem_stb_o  = wb_dmem_stb_i & ~to_hit;
        wb_mem_we_o   = wb_dmem_we_i;
        wb_mem_be_o   = wb_dmem_be_i;
        wb_mem_adr_o  = wb_dmem_adr_i;
        wb_mem_wdat_o = wb_dmem_wdat_i;
        wb_dmem_ack_o = wb_mem_ack_i;
        wb_dmem_err_o = to_hit;
        if (wb_mem_ack_i || !wb_dmem_cyc_i || to_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exotiny_mem_arb.sv
// Self-checking bench for exotiny_mem_arb: directed cases plus
// randomized traffic against a transaction-level arbiter model.
module tb_exotiny_mem_arb;

  localparam int AW  = 24;
  localparam int TMO = 4;
`ifdef EXOTINY_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          icyc = 1'b0;
  logic          istb = 1'b0;
  logic [AW-1:0] iadr = '0;
  logic          dcyc = 1'b0;
  logic          dstb = 1'b0;
  logic          dwe = 1'b0;
  logic [3:0]    dbe = '0;
  logic [AW-1:0] dadr = '0;
  logic [31:0]   dwdat = '0;
  logic          mack = 1'b0;
  logic [31:0]   mrdat = '0;

  logic          iack, ierr, dack, derr;
  logic [31:0]   irdat, drdat;
  logic          mcyc, mstb, mwe, tmo;
  logic [3:0]    mbe;
  logic [AW-1:0] madr;
  logic [31:0]   mwdat;

  int checks = 0;
  int errors = 0;

  exotiny_mem_arb #(
    .ADR_W(AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk),
    .rst_in(rst_n),
    .wb_imem_cyc_i(icyc),
    .wb_imem_stb_i(istb),
    .wb_imem_adr_i(iadr),
    .wb_imem_ack_o(iack),
    .wb_imem_err_o(ierr),
    .wb_imem_rdat_o(irdat),
    .wb_dmem_cyc_i(dcyc),
    .wb_dmem_stb_i(dstb),
    .wb_dmem_we_i(dwe),
    .wb_dmem_be_i(dbe),
    .wb_dmem_adr_i(dadr),
    .wb_dmem_wdat_i(dwdat),
    .wb_dmem_ack_o(dack),
    .wb_dmem_err_o(derr),
    .wb_dmem_rdat_o(drdat),
    .wb_mem_cyc_o(mcyc),
    .wb_mem_stb_o(mstb),
    .wb_mem_we_o(mwe),
    .wb_mem_be_o(mbe),
    .wb_mem_adr_o(madr),
    .wb_mem_wdat_o(mwdat),
    .wb_mem_ack_i(mack),
    .wb_mem_rdat_i(mrdat),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  // Model: owner 0 = nobody, 1 = imem, 2 = dmem; last = last owner.
  int owner = 0;
  int last = 2;
  int age = 0;
  bit sticky = 1'b0;
  bit m_hit;
  bit m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0;
      last = 2;
      age = 0;
      sticky = 1'b0;
    end else if (owner == 0) begin
      age = 0;
      if (icyc && istb && (!(dcyc && dstb) || last == 2)) begin
        owner = 1;
        last = 1;
      end else if (dcyc && dstb) begin
        owner = 2;
        last = 2;
      end
    end else begin
      m_cyc = (owner == 1) ? icyc : dcyc;
      m_hit = TO_EN && age == TMO && !mack;
      if (m_hit) sticky = 1'b1;
      if (mack || !m_cyc || m_hit) owner = 0;
      else age++;
    end
  end

  logic          e_cyc, e_stb, e_we, e_iack, e_dack, e_ierr, e_derr;
  logic          e_hit, e_tmo;
  logic [3:0]    e_be;
  logic [AW-1:0] e_adr;
  logic [31:0]   e_wd;
  bit            i_done = 1'b0;
  bit            d_done = 1'b0;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    e_cyc = 0; e_stb = 0; e_we = 0; e_be = '0; e_adr = '0; e_wd = '0;
    e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0; e_hit = 0;
    if (rst_n && owner != 0) begin
      e_hit = TO_EN && age == TMO && !mack;
      if (owner == 1) begin
        e_cyc = icyc && !e_hit;
        e_stb = istb && !e_hit;
        e_be = 4'hF;
        e_adr = iadr;
        e_iack = mack;
        e_ierr = e_hit;
      end else begin
        e_cyc = dcyc && !e_hit;
        e_stb = dstb && !e_hit;
        e_we = dwe;
        e_be = dbe;
        e_adr = dadr;
        e_wd = dwdat;
        e_dack = mack;
        e_derr = e_hit;
      end
    end
    e_tmo = rst_n && sticky;
    chk("ctl", {iack, ierr, dack, derr, mcyc, mstb, mwe, tmo, mbe},
        {e_iack, e_ierr, e_dack, e_derr, e_cyc, e_stb, e_we, e_tmo, e_be});
    chk("adr", madr, e_adr);
    chk("wdat", mwdat, e_wd);
    chk("irdat", irdat, mrdat);
    chk("drdat", drdat, mrdat);
    i_done = e_iack | e_ierr;
    d_done = e_dack | e_derr;
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    at_neg();
    chk("rst_cyc", {mcyc, mstb, mwe, mbe}, 0);
    chk("rst_ack", {iack, dack, ierr, derr}, 0);
    chk("rst_tmo", tmo, 0);

    // imem-only read
    step();
    icyc = 1; istb = 1; iadr = 24'h000100;
    at_neg();
    chk("t1_lat0", mcyc, 0);
    step();
    at_neg();
    chk("t1_ctl", {mcyc, mstb, mwe, mbe}, 7'b1101111);
    chk("t1_adr", madr, 32'h100);
    step();
    at_neg();
    chk("t1_wait", {iack, dack}, 0);
    step();
    mack = 1; mrdat = 32'hDEADBEEF;
    at_neg();
    chk("t1_ack", iack, 1);
    chk("t1_rdat", irdat, 32'hDEADBEEF);
    chk("t1_dack", dack, 0);
    step();
    mack = 0; mrdat = 0; icyc = 0; istb = 0;
    at_neg();
    chk("t1_idle", mcyc, 0);

    // Tie from reset: I, D, I with an idle cycle between
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    icyc = 1; istb = 1; iadr = 24'h000111;
    dcyc = 1; dstb = 1; dadr = 24'h000222; dwe = 0; dbe = 4'hF;
    mack = 1;
    at_neg();
    chk("t2_c0", mcyc, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      at_neg();
      chk("t2_cyc", mcyc, k % 2);
      if (k % 2 == 1)
        chk("t2_adr", madr, (k == 3) ? 32'h222 : 32'h111);
    end
    step();
    icyc = 0; istb = 0; dcyc = 0; dstb = 0; mack = 0;

    // dmem write with imem held; last grant was imem
    step();
    dcyc = 1; dstb = 1; dwe = 1; dbe = 4'b0011;
    dwdat = 32'h0000CAFE; dadr = 24'h000200;
    icyc = 1; istb = 1; iadr = 24'h000300;
    at_neg();
    chk("t3_c0", mcyc, 0);
    step();
    at_neg();
    chk("t3_ctl", {mcyc, mstb, mwe, mbe}, 7'b1110011);
    chk("t3_adr", madr, 32'h200);
    chk("t3_wdat", mwdat, 32'h0000CAFE);
    step();
    mack = 1;
    at_neg();
    chk("t3_ack", {dack, iack}, 2'b10);
    step();
    mack = 0; dcyc = 0; dstb = 0; dwe = 0;
    at_neg();
    chk("t3_gap", mcyc, 0);
    step();
    at_neg();
    chk("t3_ictl", {mcyc, mstb, mwe, mbe}, 7'b1101111);
    chk("t3_iadr", madr, 32'h300);
    chk("t3_iwd", mwdat, 0);
    step();
    mack = 1;
    at_neg();
    chk("t3_iack", iack, 1);
    step();
    mack = 0; icyc = 0; istb = 0;

    // dmem abandons its grant; late ack ignored
    dcyc = 1; dstb = 1; dadr = 24'h000400;
    step();
    at_neg();
    chk("t4_g1", mcyc, 1);
    step();
    step();
    dcyc = 0; dstb = 0;
    at_neg();
    chk("t4_drop", mcyc, 0);
    step();
    mack = 1;
    at_neg();
    chk("t4_late", {iack, dack, mcyc}, 0);
    step();
    mack = 0;

    // Async reset in GNT_I, then imem wins the tie
    icyc = 1; istb = 1; iadr = 24'h000500;
    step();
    #1;
    chk("t5_gnt", mcyc, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {mcyc, mstb, mbe, iack, ierr}, 0);
    chk("t5_radr", madr, 0);
    step();
    dcyc = 1; dstb = 1; dadr = 24'h000600;
    rst_n = 1'b1;
    step();
    at_neg();
    chk("t5_tie", madr, 32'h500);
    step();
    mack = 1;
    step();
    mack = 0; icyc = 0; istb = 0; dcyc = 0; dstb = 0;

    // Never-acking memory
    step();
    dcyc = 1; dstb = 1; dadr = 24'h000700;
`ifdef EXOTINY_ARB_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      step();
      at_neg();
      chk("to_err", derr, k == 5);
      chk("to_cyc", mcyc, k != 5);
    end
    step();
    dcyc = 0; dstb = 0;
    at_neg();
    chk("to_flag", tmo, 1);
    step();
    icyc = 1; istb = 1; iadr = 24'h000800;
    step();
    at_neg();
    chk("to_igr", madr, 32'h800);
    step();
    mack = 1;
    at_neg();
    chk("to_iack", iack, 1);
    chk("to_stick", tmo, 1);
`else
    for (int k = 1; k <= 7; k++) begin
      step();
      at_neg();
      chk("nto_err", {derr, tmo}, 0);
      chk("nto_cyc", mcyc, 1);
    end
    step();
    mack = 1;
    at_neg();
    chk("nto_ack", dack, 1);
`endif
    step();
    mack = 0; icyc = 0; istb = 0; dcyc = 0; dstb = 0;

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 4000; n++) begin
      step();
      if ((n % 500) > 400) mack = ($urandom_range(0, 19) == 0);
      else mack = ($urandom_range(0, 2) == 0);
      mrdat = $urandom;
      if (icyc) begin
        if (i_done) icyc = ($urandom_range(0, 1) == 0);
        else if ($urandom_range(0, 49) == 0) icyc = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        icyc = 1;
        iadr = AW'($urandom);
      end
      istb = icyc && ($urandom_range(0, 19) != 0);
      if (dcyc) begin
        if (d_done) dcyc = ($urandom_range(0, 1) == 0);
        else if ($urandom_range(0, 49) == 0) dcyc = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        dcyc = 1;
        dadr = AW'($urandom);
        dwe = 1'($urandom);
        dbe = 4'($urandom);
        dwdat = $urandom;
      end
      dstb = dcyc && ($urandom_range(0, 19) != 0);
    end
    step();
    at_neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
